quick_add_round_ctrl: RTL and testbench
=======================================

# quick_add_round_ctrl

Round sequencer for the two-player Quick Add game. It owns the 6-bit time counter: it issues the counter's increment and clear strobes and reads back the count to time each phase. It arbitrates the two player buzzers, scores each round from the datapath's correctness flag, and declares a game winner. It sits between the button synchronizers/tick generator and the score/operand display datapath.

## Interface
- SHOW_TICKS, 8: ticks operands are shown before buzzers arm (1..63)
- TIMEOUT_TICKS, 40: ticks in ARMED before round times out (1..63)
- RESULT_TICKS, 16: ticks the round result is held (1..63)
- SCORE_W, 4: score width
- WIN_SCORE, 4: score that ends the game (1..2^SCORE_W-1)
- clk_in  input  1  system clock, all logic on rising edge
- reset_n_in  input  1  asynchronous, active-low reset
- tick_in  input  1  one-cycle timebase strobe (e.g. 0.25 s)
- start_in  input  1  one-cycle start pulse
- p1_btn_in, p2_btn_in  input  1 each  synchronized, one-cycle buzzer pulses
- correct_in  input  1  datapath flag: displayed sum meets target (level)
- time_q_in  input  6  current time counter value
- time_inc_out  output  1  time counter increment enable
- time_clr_out  output  1  time counter synchronous load-to-zero
- load_operands_out  output  1  one-cycle pulse: datapath draws new operands
- state_out  output  3  IDLE=0, SHOW=1, ARMED=2, RESULT=3, DONE=4
- winner_out  output  2  round winner: 01 P1, 10 P2, 00 none
- p1_score_out, p2_score_out  output  SCORE_W each  scores
- round_done_out  output  1  one-cycle pulse on ARMED→RESULT
- game_over_out  output  1  high in DONE

## Operation
- All outputs registered; reset value 0 for every output; state IDLE; priority register prio=P1.
- time_inc_out = tick_in while in SHOW, ARMED or RESULT, forced 0 whenever time_clr_out is 1. Never both high.
- On every state transition, time_clr_out pulses for one cycle. time_q_in reads 0 from the following cycle.
- IDLE: on start_in, go to SHOW with load_operands_out pulsed.
- SHOW: on tick_in with time_q_in==SHOW_TICKS-1, go to ARMED. Buzzer presses are ignored.
- ARMED:
  - The first cycle with any press resolves the round and moves to RESULT.
  - If both buttons press in the same cycle, the player named by prio wins arbitration, then prio toggles. prio is otherwise unchanged.
  - If correct_in=1, the presser scores +1; otherwise the opponent scores +1. winner_out names the player who scored.
  - On tick_in with time_q_in==TIMEOUT_TICKS-1 and no press, it is a timeout: winner 00, no score change. A press in the same cycle takes precedence over the timeout.
  - round_done_out pulses on entry to RESULT.
- Scores saturate at 2^SCORE_W-1 and never wrap.
- RESULT: on tick_in with time_q_in==RESULT_TICKS-1:
  - If either score ≥ WIN_SCORE, go to DONE.
  - Otherwise go to SHOW with load_operands_out pulsed.
  - winner_out holds through RESULT and clears on exit.
- DONE: scores held. start_in clears both scores and prio, then goes to SHOW with load_operands_out pulsed.
- start_in is ignored in SHOW, ARMED and RESULT.
- Asserting reset_n_in low at any point returns immediately to reset values; a round in progress is abandoned.

## Timing
- Start to SHOW: one cycle. load_operands_out and time_clr_out are asserted in the cycle after start_in.
- Phase length is exactly N tick_in strobes after the clear.
- Press to result: the press is registered at edge k. At edge k, state, winner_out and the scores update, and round_done_out is asserted. time_clr_out follows in the same cycle.
- correct_in is sampled in the same cycle as the winning press.
- Async reset deassertion must be synchronized externally. The block tolerates reset release on any edge.

## Configuration
- QUICK_ADD_PENALTY_EN
  - Defined: a wrong buzz also decrements the presser's score, saturating at 0.
  - Undefined: a wrong buzz only awards the opponent.
- The game-over check uses post-penalty scores.

## Test plan
- Reset, then start_in: state 0→1, load_operands_out and time_clr_out each pulse once. After 8 ticks the state is 2.
- ARMED, p1_btn_in with correct_in=1: winner_out=01, p1_score 0→1, round_done_out pulses once. After 16 ticks the state returns to 1.
- ARMED, p1_btn_in and p2_btn_in in the same cycle, correct_in=1, twice: first round winner 01, second round winner 10 (prio toggles).
- ARMED, 40 ticks with no press: state 3, winner_out=00, scores unchanged. A press on the 40th tick's cycle wins instead.
- P2 wrong buzz with P2 score=2, correct_in=0: P1 +1. With QUICK_ADD_PENALTY_EN, P2 goes 2→1. At P1 score 4 the state goes to DONE with game_over_out=1. start_in then clears the scores.
- Reset asserted mid-ARMED with scores 3/2: all outputs 0 immediately, state IDLE, and the next start begins from 0/0.

Source files
------------

// File: rtl/quick_add_round_ctrl.sv
// Round sequencer for the two-player Quick Add game: times each phase with the external
// 6-bit counter, arbitrates buzzers, keeps score. Optional wrong-buzz penalty: QUICK_ADD_PENALTY_EN.
module quick_add_round_ctrl #(
    parameter int SHOW_TICKS    = 8,
    parameter int TIMEOUT_TICKS = 40,
    parameter int RESULT_TICKS  = 16,
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 4
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               tick_in,
    input  logic               start_in,
    input  logic               p1_btn_in,
    input  logic               p2_btn_in,
    input  logic               correct_in,
    input  logic [5:0]         time_q_in,
    output logic               time_inc_out,
    output logic               time_clr_out,
    output logic               load_operands_out,
    output logic [2:0]         state_out,
    output logic [1:0]         winner_out,
    output logic [SCORE_W-1:0] p1_score_out,
    output logic [SCORE_W-1:0] p2_score_out,
    output logic               round_done_out,
    output logic               game_over_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_ARMED  = 3'd2,
        S_RESULT = 3'd3,
        S_DONE   = 3'd4
    } state_e;

`ifdef QUICK_ADD_PENALTY_EN
    localparam bit PENALTY_EN = 1'b1;
`else
    localparam bit PENALTY_EN = 1'b0;
`endif

    localparam logic [5:0]         SHOW_LAST    = 6'(SHOW_TICKS - 1);
    localparam logic [5:0]         TIMEOUT_LAST = 6'(TIMEOUT_TICKS - 1);
    localparam logic [5:0]         RESULT_LAST  = 6'(RESULT_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
    localparam logic [SCORE_W-1:0] WIN          = SCORE_W'(WIN_SCORE);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    state_e             state_q, state_d;
    logic               prio_q, prio_d;  // 0: P1 wins a tie, 1: P2 wins a tie
    logic [1:0]         winner_q, winner_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               round_done_q, round_done_d;
    logic               time_inc_q, time_inc_d;
    logic               time_clr_q, time_clr_d;
    logic               load_q, load_d;
    logic               game_over_q, game_over_d;

    logic any_press;
    logic p1_presser;

    always_comb begin
        any_press  = p1_btn_in | p2_btn_in;
        p1_presser = p1_btn_in & (~p2_btn_in | ~prio_q);

        state_d      = state_q;
        prio_d       = prio_q;
        winner_d     = winner_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        round_done_d = 1'b0;
        load_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_SHOW;
                    load_d  = 1'b1;
                end
            end
            S_SHOW: begin
                if (tick_in && time_q_in == SHOW_LAST) state_d = S_ARMED;
            end
            S_ARMED: begin
                // A press in the timeout cycle still wins, so it is checked first.
                if (any_press) begin
                    state_d      = S_RESULT;
                    round_done_d = 1'b1;
                    if (p1_btn_in && p2_btn_in) prio_d = ~prio_q;
                    if (correct_in == p1_presser) begin
                        winner_d   = 2'b01;
                        p1_score_d = sat_inc(p1_score_q);
                        if (PENALTY_EN && !correct_in) p2_score_d = sat_dec(p2_score_q);
                    end else begin
                        winner_d   = 2'b10;
                        p2_score_d = sat_inc(p2_score_q);
                        if (PENALTY_EN && !correct_in) p1_score_d = sat_dec(p1_score_q);
                    end
                end else if (tick_in && time_q_in == TIMEOUT_LAST) begin
                    state_d      = S_RESULT;
                    round_done_d = 1'b1;
                    winner_d     = 2'b00;
                end
            end
            S_RESULT: begin
                if (tick_in && time_q_in == RESULT_LAST) begin
                    winner_d = 2'b00;
                    if (p1_score_q >= WIN || p2_score_q >= WIN) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHOW;
                        load_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (start_in) begin
                    state_d    = S_SHOW;
                    load_d     = 1'b1;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    prio_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        time_clr_d  = (state_d != state_q);
        time_inc_d  = tick_in && !time_clr_d &&
                      (state_q == S_SHOW || state_q == S_ARMED || state_q == S_RESULT);
        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            winner_q     <= 2'b00;
            p1_score_q   <= '0;
            p2_score_q   <= '0;
            round_done_q <= 1'b0;
            time_inc_q   <= 1'b0;
            time_clr_q   <= 1'b0;
            load_q       <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            winner_q     <= winner_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            round_done_q <= round_done_d;
            time_inc_q   <= time_inc_d;
            time_clr_q   <= time_clr_d;
            load_q       <= load_d;
            game_over_q  <= game_over_d;
        end
    end

    assign state_out         = state_q;
    assign winner_out        = winner_q;
    assign p1_score_out      = p1_score_q;
    assign p2_score_out      = p2_score_q;
    assign round_done_out    = round_done_q;
    assign time_inc_out      = time_inc_q;
    assign time_clr_out      = time_clr_q;
    assign load_operands_out = load_q;
    assign game_over_out     = game_over_q;

endmodule

// File: tb/tb_quick_add_round_ctrl.sv
// Directed + randomized bench for quick_add_round_ctrl with a round-level score model
// and a model of the external 6-bit time counter.
module tb_quick_add_round_ctrl;

  localparam int SHOW_TICKS    = 8;
  localparam int TIMEOUT_TICKS = 40;
  localparam int RESULT_TICKS  = 16;
  localparam int SCORE_W       = 4;
  localparam int WIN_SCORE     = 4;
  localparam int SCORE_MAX     = (1 << SCORE_W) - 1;
`ifdef QUICK_ADD_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic               clk, rst_n, tick, start, p1_btn, p2_btn, correct;
  logic [5:0]         time_q;
  logic               time_inc, time_clr, load_ops, round_done, game_over;
  logic [2:0]         state;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] p1_score, p2_score;

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_load = 0;
  int n_both = 0;
  int m_p1, m_p2, m_prio;

  quick_add_round_ctrl #(
    .SHOW_TICKS(SHOW_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .RESULT_TICKS(RESULT_TICKS),
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk_in(clk), .reset_n_in(rst_n), .tick_in(tick), .start_in(start),
    .p1_btn_in(p1_btn), .p2_btn_in(p2_btn), .correct_in(correct), .time_q_in(time_q),
    .time_inc_out(time_inc), .time_clr_out(time_clr), .load_operands_out(load_ops),
    .state_out(state), .winner_out(winner), .p1_score_out(p1_score), .p2_score_out(p2_score),
    .round_done_out(round_done), .game_over_out(game_over)
  );

  // clock / reset / environment
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external time counter the controller drives
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_q <= '0;
    else if (time_clr) time_q <= '0;
    else if (time_inc) time_q <= time_q + 6'd1;
  end

  always @(negedge clk) begin
    if (round_done) n_rd++;
    if (load_ops) n_load++;
    if (time_inc && time_clr) n_both++;
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask

  // reference model: one buzz resolved at round level
  task automatic model_press(input logic b1, input logic b2, input logic c, output logic [1:0] w);
    int who, scorer;
    if (b1 && b2) begin
      who = (m_prio == 0) ? 1 : 2;
      m_prio = 1 - m_prio;
    end else begin
      who = b1 ? 1 : 2;
    end
    scorer = c ? who : 3 - who;
    if (scorer == 1) m_p1 = (m_p1 + 1 > SCORE_MAX) ? SCORE_MAX : m_p1 + 1;
    else m_p2 = (m_p2 + 1 > SCORE_MAX) ? SCORE_MAX : m_p2 + 1;
    if (PEN && !c) begin
      if (who == 1) m_p1 = (m_p1 > 0) ? m_p1 - 1 : 0;
      else m_p2 = (m_p2 > 0) ? m_p2 - 1 : 0;
    end
    w = (scorer == 1) ? 2'b01 : 2'b10;
  endtask

  function automatic bit model_over();
    return (m_p1 >= WIN_SCORE) || (m_p2 >= WIN_SCORE);
  endfunction

  // buzz in ARMED (optionally in the same cycle as a tick), compare with the model
  task automatic buzz(input string tag, input logic b1, input logic b2, input logic c,
                      input logic with_tick);
    logic [1:0] w;
    p1_btn = b1; p2_btn = b2; correct = c; tick = with_tick;
    cyc(1);
    p1_btn = 1'b0; p2_btn = 1'b0; tick = 1'b0;
    correct = 1'($urandom_range(0, 1));
    model_press(b1, b2, c, w);
    check({tag, "_state"}, state, 3);
    check({tag, "_winner"}, winner, w);
    check({tag, "_p1"}, p1_score, m_p1);
    check({tag, "_p2"}, p2_score, m_p2);
    check({tag, "_rdone"}, round_done, 1);
    check({tag, "_clr"}, time_clr, 1);
    cyc(1);
    check({tag, "_rdone_off"}, round_done, 0);
  endtask

  // run RESULT to its end; follow into SHOW and ARMED unless the game is over
  task automatic finish_result(input string tag);
    logic [1:0] w_held;
    w_held = winner;
    ticks(RESULT_TICKS - 1);
    check({tag, "_res_hold"}, {state, winner}, {3'd3, w_held});
    tick_once();
    if (model_over()) begin
      check({tag, "_done"}, {state, winner, game_over}, {3'd4, 2'b00, 1'b1});
    end else begin
      check({tag, "_show"}, {state, winner}, {3'd1, 2'b00});
      ticks(SHOW_TICKS);
      check({tag, "_armed"}, state, 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {time_inc, time_clr, load_ops, state, winner, p1_score, p2_score,
                round_done, game_over}, 0);
  endtask

  initial begin
    int ld0, rd0, pre, pat;
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0; correct = 1'b0;
    m_p1 = 0; m_p2 = 0; m_prio = 0;
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // ticks in IDLE do nothing
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check({"idle_tick"}, {state, time_inc}, {3'd0, 1'b0});

    // start -> SHOW, then 8 ticks -> ARMED
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start", {state, load_ops, time_clr}, {3'd1, 1'b1, 1'b1});
    cyc(1);
    check("start_pulse_off", {load_ops, time_clr}, 0);
    ticks(SHOW_TICKS - 1);
    check("show_hold", state, 1);
    p1_btn = 1'b1;
    cyc(1);
    p1_btn = 1'b0;
    check("show_ignores_btn", {state, p1_score}, {3'd1, 4'd0});
    tick_once();
    check("show_to_armed", state, 2);

    // start ignored in ARMED
    ld0 = n_load;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check("armed_ignores_start", {state, 8'(n_load - ld0)}, {3'd2, 8'd0});

    buzz("p1_ok", 1'b1, 1'b0, 1'b1, 1'b0);
    finish_result("p1_ok");
    buzz("tie1", 1'b1, 1'b1, 1'b1, 1'b0);
    finish_result("tie1");
    buzz("tie2", 1'b1, 1'b1, 1'b1, 1'b0);
    finish_result("tie2");

    // timeout after 40 ticks
    rd0 = n_rd;
    ticks(TIMEOUT_TICKS - 1);
    check("to_hold", state, 2);
    tick_once();
    check("timeout", {state, winner, p1_score, p2_score},
          {3'd3, 2'b00, 4'(m_p1), 4'(m_p2)});
    check("timeout_rdone", n_rd - rd0, 1);
    finish_result("timeout");

    // press on the 40th tick's cycle wins over the timeout
    ticks(TIMEOUT_TICKS - 1);
    buzz("late_p2", 1'b0, 1'b1, 1'b1, 1'b1);
    finish_result("late_p2");

    // P2 wrong buzz: P1 scores, P2 penalised when enabled
    buzz("p2_wrong", 1'b0, 1'b1, 1'b0, 1'b0);
    finish_result("p2_wrong");

    // randomized rounds until game over
    for (int r = 0; r < 12 && !model_over(); r++) begin
      pre = $urandom_range(0, 5);
      pat = $urandom_range(1, 3);
      ticks(pre);
      buzz("rand", pat[0], pat[1], 1'($urandom_range(0, 1)), 1'b0);
      finish_result("rand");
    end
    for (int r = 0; r < 8 && !model_over(); r++) begin
      buzz("close", 1'b1, 1'b0, 1'b1, 1'b0);
      finish_result("close");
    end

    // DONE holds scores until start
    cyc(5);
    check("done_hold", {state, game_over, p1_score, p2_score},
          {3'd4, 1'b1, 4'(m_p1), 4'(m_p2)});
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    m_p1 = 0; m_p2 = 0; m_prio = 0;
    check("restart", {state, load_ops, time_clr, game_over, p1_score, p2_score},
          {3'd1, 1'b1, 1'b1, 1'b0, 8'd0});
    ticks(SHOW_TICKS);
    check("restart_armed", state, 2);

    // prio cleared by restart; then build up to 3/2
    buzz("tie_after_restart", 1'b1, 1'b1, 1'b1, 1'b0);
    finish_result("g2a");
    buzz("g2b", 1'b1, 1'b0, 1'b1, 1'b0);
    finish_result("g2b");
    buzz("g2c", 1'b1, 1'b0, 1'b1, 1'b0);
    finish_result("g2c");
    buzz("g2d", 1'b0, 1'b1, 1'b1, 1'b0);
    finish_result("g2d");
    buzz("g2e", 1'b0, 1'b1, 1'b1, 1'b0);
    finish_result("g2e");
    check("pre_reset_scores", {p1_score, p2_score}, {4'd3, 4'd2});

    // async reset mid-ARMED
    ticks(3);
    rst_n = 1'b0;
    #2;
    check_all_zero("mid_reset");
    cyc(2);
    rst_n = 1'b1;
    m_p1 = 0; m_p2 = 0; m_prio = 0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("post_reset_start", {state, p1_score, p2_score}, {3'd1, 8'd0});
    ticks(SHOW_TICKS);
    buzz("post_reset", 1'b0, 1'b1, 1'b1, 1'b0);

    check("inc_clr_exclusive", n_both, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
